// File: rtl/io_input_pkg.sv
// Shared constants for the input scanner: I/O page word addresses and scan FSM encoding.
package io_input_pkg;

  localparam logic [5:0] IO_IN_BASE = 6'b110000;
  localparam logic [5:0] IO_STATUS  = 6'b111000;
  localparam logic [5:0] IO_MASK    = 6'b111001;

  typedef enum logic [1:0] {
    StWait   = 2'd0,
    StCheck  = 2'd1,
    StCommit = 2'd2
  } scan_state_e;

endpackage

// File: rtl/io_input_sync.sv
// Two-flop synchronizer for one bus of raw asynchronous pins; intentionally not reset.
module io_input_sync #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_input_scanner.sv
// Debounced round-robin scanner for memory-mapped input ports, with change flags,
// an interrupt mask, a level irq and a combinational CPU read port.
module io_input_scanner
  import io_input_pkg::*;
#(
  parameter int unsigned N_PORTS  = 4,
  parameter int unsigned SCAN_DIV = 50,
  parameter int unsigned DB_COUNT = 4
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  input  logic [N_PORTS*32-1:0] in_port,
  output logic [31:0]          io_read_data,
  output logic                 irq
);

  localparam int unsigned PtrW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = $clog2(DB_COUNT + 1);

  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(N_PORTS - 1);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntMax    = CntW'(DB_COUNT);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam bit                DbSingle  = (DB_COUNT == 1);

  logic [N_PORTS-1:0][31:0] sync_val;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_sync
    io_input_sync #(
      .Width(32)
    ) u_sync (
      .clk_i(io_clk),
      .d_i  (in_port[32*k +: 32]),
      .q_o  (sync_val[k])
    );
  end

  scan_state_e              state_q;
  logic [PtrW-1:0]          ptr_q;
  logic [PrescW-1:0]        presc_q;
  logic [N_PORTS-1:0][31:0] in_reg_q;
  logic [N_PORTS-1:0][31:0] cand_q;
  logic [N_PORTS-1:0][CntW-1:0] cnt_q;

  logic [N_PORTS-1:0] chg_flag_q, chg_flag_d;
  logic [N_PORTS-1:0] irq_mask_q, irq_mask_d;
  logic               irq_q, irq_d;
  logic [N_PORTS-1:0] commit_set;

  logic [31:0]     cur_sync, cur_in, cur_cand;
  logic [CntW-1:0] cur_cnt, cnt_inc;
  logic [PtrW-1:0] ptr_next;
  logic            status_rd, mask_wr;

  assign cur_sync = sync_val[ptr_q];
  assign cur_in   = in_reg_q[ptr_q];
  assign cur_cand = cand_q[ptr_q];
  assign cur_cnt  = cnt_q[ptr_q];
  assign cnt_inc  = (cur_cnt == CntMax) ? CntMax : cur_cnt + 1'b1;
  assign ptr_next = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_q  <= StWait;
      ptr_q    <= '0;
      presc_q  <= '0;
      in_reg_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (presc_q == PrescLast) begin
            presc_q <= '0;
            state_q <= StCheck;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        StCheck: begin
          if (cur_sync == cur_in) begin
            cnt_q[ptr_q]  <= '0;
            cand_q[ptr_q] <= cur_sync;
            ptr_q         <= ptr_next;
            state_q       <= StWait;
          end else if (cur_sync != cur_cand) begin
            // New candidate value restarts the stability count.
            cand_q[ptr_q] <= cur_sync;
            cnt_q[ptr_q]  <= CntOne;
            if (DbSingle) begin
              state_q <= StCommit;
            end else begin
              ptr_q   <= ptr_next;
              state_q <= StWait;
            end
          end else begin
            cnt_q[ptr_q] <= cnt_inc;
            if (cnt_inc == CntMax) begin
              state_q <= StCommit;
            end else begin
              ptr_q   <= ptr_next;
              state_q <= StWait;
            end
          end
        end
        StCommit: begin
          in_reg_q[ptr_q] <= cur_cand;
          cnt_q[ptr_q]    <= '0;
          ptr_q           <= ptr_next;
          state_q         <= StWait;
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign status_rd = rd_en && (addr[7:2] == IO_STATUS);
  assign mask_wr   = wr_en && (addr[7:2] == IO_MASK);

  always_comb begin
    commit_set = '0;
    if (state_q == StCommit) begin
      commit_set[ptr_q] = 1'b1;
    end
    // A commit landing on the same edge as a status read keeps its flag.
    chg_flag_d = (status_rd ? '0 : chg_flag_q) | commit_set;
    irq_mask_d = mask_wr ? wr_data[N_PORTS-1:0] : irq_mask_q;
    irq_d      = |(chg_flag_q & irq_mask_q);
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      chg_flag_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      chg_flag_q <= chg_flag_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    io_read_data = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (addr[7:2] == IO_IN_BASE + 6'(k)) begin
        io_read_data = in_reg_q[k];
      end
    end
    if (addr[7:2] == IO_STATUS) begin
      io_read_data = 32'(chg_flag_q);
    end
    if (addr[7:2] == IO_MASK) begin
      io_read_data = 32'(irq_mask_q);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[31:8], addr[1:0], wr_data};

endmodule

// File: tb/tb_io_input_scanner.sv
// Randomized self-checking bench for io_input_scanner against a visit-schedule reference model.
module tb_io_input_scanner;

  localparam int unsigned N_PORTS  = 2;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB_COUNT = 3;

  localparam logic [31:0] A_IN0   = 32'h0000_00C0;
  localparam logic [31:0] A_IN1   = 32'h0000_00C4;
  localparam logic [31:0] A_STAT  = 32'h0000_00E0;
  localparam logic [31:0] A_MASK  = 32'h0000_00E4;
  localparam logic [31:0] A_UNMAP = 32'h0000_00BC;

  logic        io_clk;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [63:0] in_port;
  logic [31:0] io_read_data;
  logic        irq;

  int n_run;
  int n_fail;

  io_input_scanner #(
    .N_PORTS (N_PORTS),
    .SCAN_DIV(SCAN_DIV),
    .DB_COUNT(DB_COUNT)
  ) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .addr        (addr),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .in_port     (in_port),
    .io_read_data(io_read_data),
    .irq         (irq)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  // Reference model: a port is checked every SCAN_DIV+1 edges, a commit costs one extra edge,
  // and a value is accepted once DB_COUNT consecutive checks saw it.
  logic [31:0] m_s1[2], m_s2[2], m_in[2], m_last[2];
  int          m_streak[2];
  logic [1:0]  m_flag, m_mask;
  logic        m_irq;
  int          m_cd, m_port;
  bit          m_commit;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[7:2])
      6'b110000: return m_in[0];
      6'b110001: return m_in[1];
      6'b111000: return {30'b0, m_flag};
      6'b111001: return {30'b0, m_mask};
      default:   return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [1:0]  flag_n;
    logic        irq_n;
    logic [31:0] v;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_in[p] = '0; m_last[p] = '0; m_streak[p] = 0;
      end
      m_flag = '0; m_mask = '0; m_irq = 1'b0;
      m_cd = SCAN_DIV + 1; m_port = 0; m_commit = 0;
    end else begin
      irq_n  = |(m_flag & m_mask);
      flag_n = (rd_en && addr[7:2] == 6'b111000) ? 2'b00 : m_flag;
      if (wr_en && addr[7:2] == 6'b111001) m_mask = wr_data[1:0];
      if (m_commit) begin
        m_in[m_port]     = m_last[m_port];
        flag_n[m_port]   = 1'b1;
        m_streak[m_port] = 0;
        m_commit         = 0;
        m_port           = (m_port + 1) % N_PORTS;
        m_cd             = SCAN_DIV + 1;
      end else begin
        m_cd--;
        if (m_cd == 0) begin
          m_cd = SCAN_DIV + 1;
          v = m_s2[m_port];
          if (v == m_in[m_port]) begin
            m_streak[m_port] = 0; m_last[m_port] = v;
          end else if (v != m_last[m_port]) begin
            m_last[m_port] = v; m_streak[m_port] = 1;
          end else if (m_streak[m_port] < DB_COUNT) begin
            m_streak[m_port]++;
          end
          if (v != m_in[m_port] && m_streak[m_port] == DB_COUNT) m_commit = 1;
          else m_port = (m_port + 1) % N_PORTS;
        end
      end
      m_flag = flag_n;
      m_irq  = irq_n;
    end
    for (int p = 0; p < 2; p++) begin
      m_s2[p] = m_s1[p];
      m_s1[p] = in_port[32*p +: 32];
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd_en = r; wr_en = w; addr = a; wr_data = d;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    reset = 1'b1;
    in_port = '0;
    drive(1'b0, 1'b0, A_IN0, 32'h0);
    repeat (3) cycle();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: a = A_IN0;
        1: a = A_IN1;
        2: a = A_STAT;
        default: a = A_MASK;
      endcase
      drive(1'b0, 1'b0, a, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== 32'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: addr=%h rd=%h irq=%b, want 0/0", a, io_read_data, irq);
      end
      cycle();
    end
  endtask

  task automatic test_debounce();
    bit done = 0;
    in_port[31:0] = 32'h0000_00A5;
    for (int i = 0; i < 120 && !done; i++) begin
      drive(1'b0, 1'b0, A_IN0, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL debounce_step: rd=%h irq=%b, want %h/%b", io_read_data, irq, m_read(addr), m_irq);
      end
      if (io_read_data === 32'h0000_00A5) done = 1;
      else cycle();
    end
    n_run++;
    if (!done) begin
      n_fail++;
      $display("FAIL debounce_commit: in_reg0=%h, want 000000a5 within budget", io_read_data);
    end
    drive(1'b1, 1'b0, A_STAT, 32'h0);
    #1;
    n_run++;
    if (io_read_data !== 32'h1) begin
      n_fail++;
      $display("FAIL debounce_status1: got %h, want 00000001", io_read_data);
    end
    cycle();
    #1;
    n_run++;
    if (io_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL debounce_status2: got %h, want 00000000", io_read_data);
    end
    cycle();
  endtask

  task automatic test_glitch();
    bit done = 0;
    in_port[63:32] = 32'h1;
    for (int i = 0; i < 120 && !done; i++) begin
      drive(1'b0, 1'b0, A_IN1, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL glitch_step: rd=%h irq=%b, want %h/%b", io_read_data, irq, m_read(addr), m_irq);
      end
      cycle();
      if (m_streak[1] == 2) done = 1;
    end
    in_port[63:32] = 32'h0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, (i % 2 == 0) ? A_IN1 : A_STAT, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== 32'h0) begin
        n_fail++;
        $display("FAIL glitch_hold: addr=%h rd=%h, want 00000000", addr, io_read_data);
      end
      cycle();
    end
  endtask

  task automatic test_irq();
    int t_commit = -1;
    int t_irq = -1;
    bit done = 0;
    drive(1'b0, 1'b1, A_MASK, 32'h2);
    #1;
    cycle();
    drive(1'b0, 1'b0, A_MASK, 32'h0);
    #1;
    n_run++;
    if (io_read_data !== 32'h2) begin
      n_fail++;
      $display("FAIL irq_mask_read: got %h, want 00000002", io_read_data);
    end
    in_port[63:32] = 32'h1234_5678;
    for (int i = 0; i < 150 && t_irq < 0; i++) begin
      drive(1'b0, 1'b0, A_IN1, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL irq_step: rd=%h irq=%b, want %h/%b", io_read_data, irq, m_read(addr), m_irq);
      end
      if (t_commit < 0 && io_read_data === 32'h1234_5678) t_commit = i;
      if (irq === 1'b1) t_irq = i;
      else cycle();
    end
    n_run++;
    if (t_commit < 0 || t_irq - t_commit != 1) begin
      n_fail++;
      $display("FAIL irq_latency: commit at %0d irq at %0d, want irq one cycle after", t_commit, t_irq);
    end
    drive(1'b1, 1'b0, A_STAT, 32'h0);
    #1;
    n_run++;
    if (io_read_data !== 32'h2) begin
      n_fail++;
      $display("FAIL irq_status: got %h, want 00000002", io_read_data);
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, A_STAT, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL irq_clear_step: rd=%h irq=%b, want %h/%b", io_read_data, irq, m_read(addr), m_irq);
      end
      cycle();
    end
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_cleared: irq=%b, want 0", irq);
    end
    in_port[31:0] = 32'h0000_0F0F;
    for (int i = 0; i < 150 && !done; i++) begin
      drive(1'b0, 1'b0, A_IN0, 32'h0);
      #1;
      n_run++;
      if (irq !== 1'b0 || io_read_data !== m_read(addr)) begin
        n_fail++;
        $display("FAIL irq_masked: rd=%h irq=%b, want %h/0", io_read_data, irq, m_read(addr));
      end
      if (io_read_data === 32'h0000_0F0F) done = 1;
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_run++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL irq_masked_after: irq=%b, want 0", irq);
      end
      cycle();
    end
  endtask

  task automatic test_coincident();
    bit done = 0;
    bit hit = 0;
    in_port[63:32] = 32'h0000_CAFE;
    for (int i = 0; i < 150 && !done; i++) begin
      drive(1'b0, 1'b0, A_IN1, 32'h0);
      #1;
      if (io_read_data === 32'h0000_CAFE) done = 1;
      cycle();
    end
    in_port[31:0] = 32'h5A5A_0000;
    for (int i = 0; i < 150 && !hit; i++) begin
      drive(m_commit && m_port == 0, 1'b0, A_STAT, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL coinc_step: rd=%h irq=%b, want %h/%b", io_read_data, irq, m_read(addr), m_irq);
      end
      if (rd_en) hit = 1;
      cycle();
    end
    drive(1'b0, 1'b0, A_STAT, 32'h0);
    #1;
    n_run++;
    if (!hit || io_read_data !== 32'h1) begin
      n_fail++;
      $display("FAIL coinc_flag: status=%h hit=%b, want 00000001", io_read_data, hit);
    end
    drive(1'b0, 1'b0, A_IN0, 32'h0);
    #1;
    n_run++;
    if (io_read_data !== 32'h5A5A_0000) begin
      n_fail++;
      $display("FAIL coinc_inreg: got %h, want 5a5a0000", io_read_data);
    end
  endtask

  task automatic test_reset_mid();
    bit done = 0;
    int k_hit = -1;
    logic [31:0] chk_a[5];
    in_port[63:32] = 32'h0BAD_F00D;
    drive(1'b0, 1'b1, A_MASK, 32'h3);
    #1;
    cycle();
    drive(1'b0, 1'b0, A_IN1, 32'h0);
    for (int i = 0; i < 150 && !done; i++) begin
      #1;
      cycle();
      if (m_streak[1] == 2) done = 1;
    end
    in_port[31:0] = 32'h0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk_a[0] = A_IN0; chk_a[1] = A_IN1; chk_a[2] = A_STAT; chk_a[3] = A_MASK;
    chk_a[4] = 32'hFFFF_FF00 | A_UNMAP;
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b0, chk_a[j], 32'h0);
      #1;
      n_run++;
      if (io_read_data !== 32'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_zero: addr=%h rd=%h irq=%b, want 0/0", chk_a[j], io_read_data, irq);
      end
    end
    for (int k = 0; k < 60 && k_hit < 0; k++) begin
      drive(1'b0, 1'b0, A_IN1, 32'h0);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL rstmid_step: rd=%h irq=%b, want %h/%b", io_read_data, irq, m_read(addr), m_irq);
      end
      if (io_read_data === 32'h0BAD_F00D) k_hit = k;
      else cycle();
    end
    n_run++;
    if (k_hit != 3 * N_PORTS * (SCAN_DIV + 1) + 1) begin
      n_fail++;
      $display("FAIL rstmid_fresh: commit after %0d cycles, want %0d", k_hit,
               3 * N_PORTS * (SCAN_DIV + 1) + 1);
    end
    drive(1'b0, 1'b0, A_UNMAP, 32'h0);
    #1;
    n_run++;
    if (io_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h, want 00000000", io_read_data);
    end
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] a, v;
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 79) == 0) begin
          case ($urandom_range(0, 3))
            0: v = 32'h0;
            1: v = 32'h0000_00A5;
            2: v = 32'hFFFF_0000;
            default: v = $urandom;
          endcase
          in_port[32*p +: 32] = v;
        end
      end
      case ($urandom_range(0, 4))
        0: a = A_IN0;
        1: a = A_IN1;
        2: a = A_STAT;
        3: a = A_MASK;
        default: a = $urandom;
      endcase
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, a, $urandom);
      #1;
      n_run++;
      if (io_read_data !== m_read(addr) || irq !== m_irq) begin
        n_fail++;
        $display("FAIL random_step %0d: addr=%h rd=%h irq=%b, want %h/%b", i, addr,
                 io_read_data, irq, m_read(addr), m_irq);
      end
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0;
    n_fail = 0;
    reset = 1'b1;
    in_port = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int p = 0; p < 2; p++) begin
      m_s1[p] = '0; m_s2[p] = '0;
    end
    test_reset();
    test_debounce();
    test_glitch();
    test_irq();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
